apb_master_arb: RTL and testbench

APB_MASTER_ARB -- requirements
Module: apb_master_arb

---
 rtl/apb_master_arb.sv | 190 +++++++++++++++++++
 tb/tb_apb_master_arb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arb.sv
// apb_master_arb
//   Two-requester APB master. A round-robin arbiter picks one request while
//   the master is idle. The request's fields are captured and then driven as
//   a standard SETUP/ACCESS APB transfer. A one-cycle response pulse goes back
//   to the granted requester. An ACCESS phase that runs TIMEOUT cycles
//   without pready is aborted and reported as an error.
//
// Ports
//   pclk, presetn           clock, synchronous active-low reset
//   req_valid/ready [1:0]   per-requester handshake (ready is combinational)
//   req_write/addr/wdata/strb/prot   per-requester transfer fields, packed
//   rsp_valid [1:0]         one-cycle completion pulse to the granted requester
//   rsp_rdata, rsp_err      completion payload (0 when rsp_valid is 0)
//   psel..pwdata            APB master outputs
//   prdata, pready, pslverr APB slave inputs
//
// state  | meaning
// IDLE   | no transfer; arbitrate and accept a request
// SETUP  | psel=1 penable=0 for one cycle
// ACCESS | psel=1 penable=1 until pready or timeout
module apb_master_arb #(
    parameter int unsigned AWIDTH  = 10,
    parameter logic [2:0]  DSIZE   = 3'd2,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned DBYTES = 1 << DSIZE,
    localparam int unsigned DWIDTH = DBYTES * 8
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*AWIDTH-1:0]   req_addr,
    input  logic [2*DWIDTH-1:0]   req_wdata,
    input  logic [2*DBYTES-1:0]   req_strb,
    input  logic [5:0]            req_prot,
    output logic [1:0]            rsp_valid,
    output logic [DWIDTH-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [2:0]            pprot,
    output logic [AWIDTH-1:0]     paddr,
    output logic [DBYTES-1:0]     pstrb,
    output logic [DWIDTH-1:0]     pwdata,
    input  logic [DWIDTH-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                pwrite_q, pwrite_d;
    logic [2:0]          pprot_q, pprot_d;
    logic [AWIDTH-1:0]   paddr_q, paddr_d;
    logic [DBYTES-1:0]   pstrb_q, pstrb_d;
    logic [DWIDTH-1:0]   pwdata_q, pwdata_d;
    logic [7:0]          wait_cnt_q, wait_cnt_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                accept;
    logic                timeout_hit;
    logic                win_idx;
    logic                win_write;
    logic [AWIDTH-1:0]   win_addr;
    logic [DWIDTH-1:0]   win_wdata;
    logic [DBYTES-1:0]   win_strb;
    logic [2:0]          win_prot;

    // Round robin: on contention the requester not granted last time wins.
    always_comb begin
        win_idx   = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        win_write = req_write[win_idx];
        win_addr  = win_idx ? req_addr[2*AWIDTH-1 -: AWIDTH]  : req_addr[AWIDTH-1:0];
        win_wdata = win_idx ? req_wdata[2*DWIDTH-1 -: DWIDTH] : req_wdata[DWIDTH-1:0];
        win_strb  = win_idx ? req_strb[2*DBYTES-1 -: DBYTES]  : req_strb[DBYTES-1:0];
        win_prot  = win_idx ? req_prot[5:3]                   : req_prot[2:0];
    end

    assign accept      = (state_q == ST_IDLE) && (req_valid != 2'b00);
    assign timeout_hit = (wait_cnt_q == TO_LAST);

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;      // requester 0 wins the first contention
            grant_q      <= 1'b0;
            pwrite_q     <= 1'b0;
            pprot_q      <= '0;
            paddr_q      <= '0;
            pstrb_q      <= '0;
            pwdata_q     <= '0;
            wait_cnt_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            pwrite_q     <= pwrite_d;
            pprot_q      <= pprot_d;
            paddr_q      <= paddr_d;
            pstrb_q      <= pstrb_d;
            pwdata_q     <= pwdata_d;
            wait_cnt_q   <= wait_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready || timeout_hit) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath: APB fields hold their last value outside an accept.
    always_comb begin
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        pwrite_d     = pwrite_q;
        pprot_d      = pprot_q;
        paddr_d      = paddr_q;
        pstrb_d      = pstrb_q;
        pwdata_d     = pwdata_q;
        wait_cnt_d   = wait_cnt_q;
        rsp_valid_d  = 2'b00;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_grant_d = win_idx;
                    grant_d      = win_idx;
                    pwrite_d     = win_write;
                    pprot_d      = win_prot;
                    paddr_d      = win_addr;
                    pstrb_d      = win_write ? win_strb  : '0;
                    pwdata_d     = win_write ? win_wdata : '0;
                end
            end
            ST_SETUP: wait_cnt_d = '0;
            ST_ACCESS: begin
                // pready on the last allowed cycle still counts as a completion
                if (pready) begin
                    rsp_valid_d = grant_q ? 2'b10 : 2'b01;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end else if (timeout_hit) begin
                    rsp_valid_d = grant_q ? 2'b10 : 2'b01;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // req_ready is gated by presetn so it reads 0 throughout reset.
    always_comb begin
        psel      = (state_q != ST_IDLE);
        penable   = (state_q == ST_ACCESS);
        req_ready = (presetn && accept) ? (win_idx ? 2'b10 : 2'b01) : 2'b00;
    end

    assign pwrite    = pwrite_q;
    assign pprot     = pprot_q;
    assign paddr     = paddr_q;
    assign pstrb     = pstrb_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
module tb_apb_master_arb;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DB = 4;

    logic            pclk = 1'b0;
    logic            presetn;
    logic [1:0]      req_valid, req_ready, req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*DB-1:0] req_strb;
    logic [5:0]      req_prot;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            psel, penable, pwrite;
    logic [2:0]      pprot;
    logic [AW-1:0]   paddr;
    logic [DB-1:0]   pstrb;
    logic [DW-1:0]   pwdata, prdata;
    logic            pready, pslverr;

    apb_master_arb dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pprot(pprot),
        .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [1:0]  vld;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t rsp_exp_q[$];
    int   grant_exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*DB +: DB]  = s;
        req_prot[i*3 +: 3]    = p;
    endtask

    // Grant monitor
    always @(negedge pclk) begin : grant_mon
        int g;
        if (mon_en && req_ready != 2'b00) begin
            if (grant_exp_q.size() == 0) begin
                chk("grant_unexpected", 64'(req_ready), 64'd0);
            end else begin
                g = grant_exp_q.pop_front();
                chk("grant", 64'(req_ready), (g == 1) ? 64'd2 : 64'd1);
            end
        end
    end

    // Response monitor
    always @(negedge pclk) begin : rsp_mon
        rsp_t e;
        if (mon_en) begin
            if (rsp_valid != 2'b00) begin
                if (rsp_exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = rsp_exp_q.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(e.vld));
                    chk("rsp_err",   64'(rsp_err),   64'(e.err));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                end
            end else begin
                chk("rsp_idle_zero", 64'({rsp_err, rsp_rdata}), 64'd0);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cnt;
        presetn = 1'b0;
        req_valid = 2'b11;
        req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        set_req(0, 1'b1, 10'h3FF, 32'hFFFF_FFFF, 4'hF, 3'h7);
        set_req(1, 1'b1, 10'h155, 32'h5555_5555, 4'hF, 3'h7);
        tick(); tick();
        @(negedge pclk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_psel",      64'(psel), 64'd0);
        chk("rst_penable",   64'(penable), 64'd0);
        chk("rst_paddr",     64'(paddr), 64'd0);
        chk("rst_pwdata",    64'(pwdata), 64'd0);
        chk("rst_pstrb",     64'(pstrb), 64'd0);
        chk("rst_pprot",     64'(pprot), 64'd0);
        chk("rst_pwrite",    64'(pwrite), 64'd0);
        chk("rst_rsp",       64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);

        tick();
        presetn = 1'b1;
        req_valid = 2'b00;
        mon_en = 1'b1;

        // Write from requester 0, zero wait states
        tick();
        set_req(0, 1'b1, 10'h010, 32'hA5A5_A5A5, 4'hF, 3'b010);
        req_valid = 2'b01;
        pready = 1'b1;
        grant_exp_q.push_back(0);
        rsp_exp_q.push_back('{vld: 2'b01, err: 1'b0, rdata: 32'h0});
        @(negedge pclk);
        chk("wr_c0_psel", 64'(psel), 64'd0);
        tick(); req_valid = 2'b00;
        @(negedge pclk);
        chk("wr_c1_setup", 64'({psel, penable}), 64'b10);
        chk("wr_c1_paddr", 64'(paddr), 64'h010);
        chk("wr_c1_pwdata", 64'(pwdata), 64'hA5A5_A5A5);
        chk("wr_c1_pstrb_pwrite_pprot", 64'({pstrb, pwrite, pprot}), 64'({4'hF, 1'b1, 3'b010}));
        tick();
        @(negedge pclk);
        chk("wr_c2_access", 64'({psel, penable}), 64'b11);
        tick();
        @(negedge pclk);
        chk("wr_c3_rsp_valid", 64'(rsp_valid), 64'b01);
        chk("wr_c3_psel", 64'(psel), 64'd0);
        chk("idle_hold_paddr", 64'(paddr), 64'h010);

        // Read from requester 1 with three wait states
        tick();
        set_req(1, 1'b0, 10'h020, 32'hDEAD_BEEF, 4'hF, 3'b101);
        req_valid = 2'b10;
        pready = 1'b0;
        prdata = 32'h0;
        grant_exp_q.push_back(1);
        rsp_exp_q.push_back('{vld: 2'b10, err: 1'b0, rdata: 32'h1234_5678});
        @(negedge pclk);
        tick(); req_valid = 2'b00;
        @(negedge pclk);
        chk("rd_setup", 64'({psel, penable}), 64'b10);
        chk("rd_setup_fields", 64'({paddr, pwrite, pwdata, pstrb, pprot}),
            64'({10'h020, 1'b0, 32'h0, 4'h0, 3'b101}));
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) begin
                pready = 1'b1;
                prdata = 32'h1234_5678;
            end
            @(negedge pclk);
            chk("rd_access", 64'({psel, penable}), 64'b11);
            chk("rd_paddr_stable", 64'(paddr), 64'h020);
        end
        tick(); pready = 1'b0; prdata = 32'h0;
        @(negedge pclk);
        chk("rd_done_psel", 64'(psel), 64'd0);

        // Contention straight after reset: 0,1,0,1 every third cycle
        tick(); presetn = 1'b0;
        @(negedge pclk);
        tick();
        presetn = 1'b1;
        pready = 1'b1;
        set_req(0, 1'b1, 10'h100, 32'h1111_1111, 4'hF, 3'b000);
        set_req(1, 1'b1, 10'h200, 32'h2222_2222, 4'h3, 3'b000);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            grant_exp_q.push_back(i % 2);
            rsp_exp_q.push_back('{vld: (i % 2 == 1) ? 2'b10 : 2'b01, err: 1'b0, rdata: 32'h0});
        end
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) tick();
            if (c == 10) req_valid = 2'b00;
            @(negedge pclk);
            chk("cont_accept_cycle", 64'(req_ready != 2'b00), 64'(c % 3 == 0));
            if (c % 3 == 1)
                chk("cont_setup_paddr", 64'(paddr), ((c / 3) % 2 == 0) ? 64'h100 : 64'h200);
        end
        tick(); tick();
        @(negedge pclk);

        // Timeout: pready held low
        tick();
        set_req(0, 1'b0, 10'h030, 32'h0, 4'h0, 3'b001);
        req_valid = 2'b01;
        pready = 1'b0;
        prdata = 32'hCAFE_F00D;
        grant_exp_q.push_back(0);
        rsp_exp_q.push_back('{vld: 2'b01, err: 1'b1, rdata: 32'h0});
        @(negedge pclk);
        tick(); req_valid = 2'b00;
        @(negedge pclk);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            @(negedge pclk);
            if (penable) cnt++;
            else break;
        end
        chk("to_access_cycles", 64'(cnt), 64'd16);
        chk("to_psel_dropped", 64'(psel), 64'd0);
        prdata = 32'h0;

        // pready arriving on the last allowed ACCESS cycle completes normally
        tick();
        set_req(0, 1'b1, 10'h060, 32'h0F0F_0F0F, 4'h5, 3'b000);
        req_valid = 2'b01;
        grant_exp_q.push_back(0);
        rsp_exp_q.push_back('{vld: 2'b01, err: 1'b0, rdata: 32'h0});
        @(negedge pclk);
        tick(); req_valid = 2'b00;
        @(negedge pclk);
        for (int k = 1; k <= 16; k++) begin
            tick();
            pready = (k == 16);
            @(negedge pclk);
            chk("edge_access", 64'(penable), 64'd1);
        end
        tick(); pready = 1'b0;
        @(negedge pclk);
        chk("edge_done_psel", 64'(psel), 64'd0);

        // Slave error on a read
        tick();
        set_req(1, 1'b0, 10'h040, 32'h0, 4'h0, 3'b000);
        req_valid = 2'b10;
        pready = 1'b1;
        pslverr = 1'b1;
        prdata = 32'h0BAD_BEEF;
        grant_exp_q.push_back(1);
        rsp_exp_q.push_back('{vld: 2'b10, err: 1'b1, rdata: 32'h0BAD_BEEF});
        @(negedge pclk);
        tick(); req_valid = 2'b00;
        @(negedge pclk);
        tick();
        @(negedge pclk);
        tick(); pslverr = 1'b0; pready = 1'b0; prdata = 32'h0;
        @(negedge pclk);

        // Reset in the middle of ACCESS from requester 0
        tick();
        set_req(0, 1'b0, 10'h050, 32'h0, 4'h0, 3'b000);
        req_valid = 2'b01;
        grant_exp_q.push_back(0);
        @(negedge pclk);
        tick(); req_valid = 2'b00;
        @(negedge pclk);
        tick();
        @(negedge pclk);
        chk("mid_in_access", 64'(penable), 64'd1);
        tick(); presetn = 1'b0;
        @(negedge pclk);
        tick();
        presetn = 1'b1;
        pready = 1'b1;
        set_req(0, 1'b1, 10'h070, 32'h7777_7777, 4'hF, 3'b000);
        set_req(1, 1'b1, 10'h080, 32'h8888_8888, 4'hF, 3'b000);
        req_valid = 2'b11;
        grant_exp_q.push_back(0);
        rsp_exp_q.push_back('{vld: 2'b01, err: 1'b0, rdata: 32'h0});
        @(negedge pclk);
        chk("mid_rst_psel", 64'(psel), 64'd0);
        chk("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
        chk("mid_rst_winner", 64'(req_ready), 64'b01);
        tick(); req_valid = 2'b00;
        @(negedge pclk);
        tick();
        @(negedge pclk);
        tick();
        @(negedge pclk);
        tick(); tick();
        @(negedge pclk);

        chk("grant_queue_empty", 64'(grant_exp_q.size()), 64'd0);
        chk("rsp_queue_empty", 64'(rsp_exp_q.size()), 64'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
